// File: rtl/fifo_pkg.sv
// Shared constants and state encoding for the FIFO read path.
package fifo_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH_LOG = 8;
    localparam int RD_LAT        = 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_reader_if.sv
// Read-side bundle: FIFO controller / RAM port towards the reader, and the
// valid/ready output stream leaving it.
interface fifo_reader_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic             fifo_read_req;
    logic [WIDTH-1:0] ram_read_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  fifo_empty,
        input  ram_read_data,
        input  out_ready,
        output fifo_read_req,
        output out_valid,
        output out_data
    );

    modport slave (
        output fifo_empty,
        output ram_read_data,
        output out_ready,
        input  fifo_read_req,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fifo_skid_buf.sv
// Two-entry FIFO-ordered output buffer; data always shows the head entry.
module fifo_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] data,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == 2'd2);
    assign empty = (count_r == 2'd0);
    assign count = count_r;
    assign data  = mem_r[rd_ptr_r];

    // A full buffer only accepts a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || pop);
    assign do_pop_s  = pop && !empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Reads words out of a FIFO/RAM pair with one-cycle read latency and presents
// them on a valid/ready stream through a two-entry buffer.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH_LOG = DEF_DEPTH_LOG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    fifo_reader_if.master bus,
    output logic          busy,
    output logic [15:0]   word_count
);

    if (DEPTH_LOG < 1 || RD_LAT != 1) begin : g_param_check
        $error("fifo_reader: unsupported DEPTH_LOG or RAM read latency");
    end

    state_t           state_r;
    state_t           state_n;
    logic             inflight_r;
    logic [15:0]      word_count_r;
    logic             read_req_s;
    logic             handshake_s;
    logic [1:0]       buf_count_s;
    logic             buf_full_s;
    logic             buf_empty_s;
    logic [WIDTH-1:0] head_s;

    // Credit check: the buffer slots must cover every word already in flight.
    assign read_req_s  = enable && !bus.fifo_empty && (state_r == ACTIVE) &&
                         ((buf_count_s + {1'b0, inflight_r}) < 2'd2);
    assign handshake_s = !buf_empty_s && bus.out_ready;

    assign bus.fifo_read_req = read_req_s;
    assign bus.out_valid     = !buf_empty_s;
    assign bus.out_data      = head_s;
    assign busy              = inflight_r || !buf_empty_s;
    assign word_count        = word_count_r;

    fifo_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight_r),
        .pop     (handshake_s),
        .in_data (bus.ram_read_data),
        .data    (head_s),
        .count   (buf_count_s),
        .full    (buf_full_s),
        .empty   (buf_empty_s)
    );

    // Control state, read tracking and delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            inflight_r   <= 1'b0;
            word_count_r <= 16'd0;
        end else begin
            state_r    <= state_n;
            inflight_r <= read_req_s;
            if (handshake_s) begin
                word_count_r <= word_count_r + 16'd1;
            end
        end
    end

    // Next-state logic; draining continues regardless of state.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (enable) state_n = ACTIVE;
                else        state_n = IDLE;
            end
            ACTIVE: begin
                if (!enable) state_n = STOPPING;
                else         state_n = ACTIVE;
            end
            STOPPING: begin
                if (enable)                         state_n = ACTIVE;
                else if (!inflight_r && buf_empty_s) state_n = IDLE;
                else                                 state_n = STOPPING;
            end
            default: state_n = IDLE;
        endcase
    end

    logic unused_s;
    assign unused_s = buf_full_s;

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a queue-based FIFO/RAM model feeds the DUT,
// expected words are queued when written, and a monitor checks every handshake.
module tb_fifo_reader;
    import fifo_pkg::*;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        busy;
    logic [15:0] word_count;

    fifo_reader_if #(.WIDTH(W)) bus ();

    fifo_reader #(.WIDTH(W), .DEPTH_LOG(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bus        (bus),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] fifo_q [$];
    logic [W-1:0] exp_q  [$];
    int           reqs_seen = 0;
    bit           read_cap = 1'b0;
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(int n);
        rst    = 1'b1;
        enable = 1'b0;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic wait_wc(string name, int target, int budget);
        for (int i = 0; i < budget && word_count != target[15:0]; i++) @(negedge clk);
        check(name, word_count, target);
    endtask

    task automatic find_req(string name, int budget);
        int found;
        found = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.fifo_read_req && !bus.fifo_empty) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    // FIFO controller + RAM model: an accepted request returns the head word next cycle.
    always @(negedge clk) begin
        read_cap = bus.fifo_read_req && !bus.fifo_empty;
        if (read_cap) reqs_seen++;
    end

    always @(posedge clk) begin
        #1;
        if (read_cap && fifo_q.size() > 0) bus.ram_read_data = fifo_q.pop_front();
        else                               bus.ram_read_data = W'($urandom);
        read_cap       = 1'b0;
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    // Output monitor: ordering, stall stability and illegal reads.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.fifo_read_req) check("req_while_empty", bus.fifo_empty, 0);
            if (prev_stall) begin
                check("stall_valid", bus.out_valid, 1);
                check("stall_data", bus.out_data, prev_data);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", bus.out_data);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int rs0;
        int n;
        bit done;

        bus.out_ready     = 1'b1;
        bus.fifo_empty    = 1'b1;
        bus.ram_read_data = '0;
        rst               = 1'b1;
        enable            = 1'b1;
        fifo_q.push_back(8'h77);
        exp_q.push_back(8'h77);

        // Reset held with work pending: nothing may come out.
        repeat (3) begin
            tick();
            @(negedge clk);
            check("rst_req", bus.fifo_read_req, 0);
            check("rst_valid", bus.out_valid, 0);
            check("rst_wc", word_count, 0);
            check("rst_busy", busy, 0);
        end
        tick();
        rst = 1'b0;
        wait_wc("rst_release_wc", 1, 20);

        // Single word with latency check.
        do_reset(2);
        bus.out_ready = 1'b1;
        rs0 = reqs_seen;
        fifo_q.push_back(8'hA5);
        exp_q.push_back(8'hA5);
        tick();
        enable = 1'b1;
        find_req("single_req_found", 10);
        @(negedge clk);
        check("single_n1_valid", bus.out_valid, 0);
        @(negedge clk);
        check("single_n2_valid", bus.out_valid, 1);
        check("single_n2_data", bus.out_data, 8'hA5);
        repeat (3) @(negedge clk);
        check("single_wc", word_count, 1);
        check("single_busy", busy, 0);
        check("single_reqs", reqs_seen - rs0, 1);

        // Backpressure: buffer fills with two words, then drains in order.
        do_reset(2);
        bus.out_ready = 1'b0;
        rs0 = reqs_seen;
        for (int i = 1; i <= 5; i++) begin
            fifo_q.push_back(W'(i));
            exp_q.push_back(W'(i));
        end
        tick();
        enable = 1'b1;
        repeat (12) @(negedge clk);
        check("bp_reqs", reqs_seen - rs0, 2);
        check("bp_valid", bus.out_valid, 1);
        check("bp_head", bus.out_data, 8'h01);
        check("bp_fifo_left", fifo_q.size(), 3);
        check("bp_busy", busy, 1);
        tick();
        bus.out_ready = 1'b1;
        wait_wc("bp_wc", 5, 60);
        check("bp_exp_left", exp_q.size(), 0);

        // Stop after the third read.
        do_reset(2);
        bus.out_ready = 1'b1;
        rs0 = reqs_seen;
        for (int i = 0; i < 10; i++) begin
            fifo_q.push_back(W'(8'h10 + i));
            exp_q.push_back(W'(8'h10 + i));
        end
        tick();
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 3; i++) begin
            @(negedge clk);
            if (bus.fifo_read_req && !bus.fifo_empty) n++;
        end
        check("stop_found", n, 3);
        tick();
        enable = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("stop_reqs", reqs_seen - rs0, 3);
        check("stop_wc", word_count, 3);
        check("stop_busy", busy, 0);
        check("stop_state", dut.state_r, IDLE);
        check("stop_fifo_left", fifo_q.size(), 7);
        check("stop_exp_left", exp_q.size(), 7);
        fifo_q.delete();
        exp_q.delete();

        // Reset in the cycle after a read: the returning word must be dropped.
        do_reset(2);
        bus.out_ready = 1'b1;
        fifo_q.push_back(8'h3C);
        exp_q.push_back(8'h3C);
        tick();
        enable = 1'b1;
        find_req("mf_req_found", 10);
        tick();
        rst    = 1'b1;
        enable = 1'b0;
        tick();
        rst = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (5) begin
            @(negedge clk);
            check("mf_valid", bus.out_valid, 0);
            check("mf_wc", word_count, 0);
            check("mf_busy", busy, 0);
        end

        // Random fill and backpressure for 1000 words.
        do_reset(2);
        enable = 1'b1;
        done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; ) begin
                    tick();
                    if ($urandom_range(1, 0) == 1) begin
                        logic [W-1:0] v;
                        v = W'($urandom);
                        fifo_q.push_back(v);
                        exp_q.push_back(v);
                        i++;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    tick();
                    bus.out_ready = ($urandom_range(1, 0) == 1);
                end
            end
        join
        bus.out_ready = 1'b1;
        wait_wc("rand_wc", 1000, 5000);
        check("rand_exp_left", exp_q.size(), 0);
        check("rand_fifo_left", fifo_q.size(), 0);
        repeat (3) @(negedge clk);
        check("rand_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
